// File: rtl/or_acc_ctrl.sv
// Burst OR-accumulator: ORs len upstream words into an accumulator and
// publishes the reduction in result with a one-cycle done pulse.
package or_acc_pkg;
  typedef logic [7:0] wsizeN;
endpackage

module or_m #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a | b;
endmodule

// Handshake: a word transfers on a rising edge where in_valid && in_ready are
// both high; in_ready is high only in ACC and does not depend on in_valid.
module or_acc_ctrl
  import or_acc_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             clear,
  input  logic             in_valid,
  input  wsizeN            in_data,
  output logic             in_ready,
  output wsizeN            result,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state_dbg
);
  localparam int W = $bits(wsizeN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  wsizeN            acc_q;
  wsizeN            acc_d;
  wsizeN            result_q;
  logic [LEN_W-1:0] cnt_q;
  logic             beat;

  or_m #(.W(W)) u_or (
    .a (acc_q),
    .b (in_data),
    .y (acc_d)
  );

  assign beat = in_valid && (state_q == ACC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (clear) begin
      // Abort wins over everything, including a final beat; result is kept.
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q <= len;
            acc_q <= '0;
            if (len == '0) begin
              state_q  <= DONE;
              result_q <= '0;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q  <= DONE;
              result_q <= acc_d;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ACC);
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_or_acc_ctrl.sv
// Directed bench for or_acc_ctrl: each task drives one scenario and checks
// outputs one time unit after the rising edge.
module tb_or_acc_ctrl;
  import or_acc_pkg::*;

  localparam int LEN_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             clear;
  logic             in_valid;
  wsizeN            in_data;
  logic             in_ready;
  wsizeN            result;
  logic             done;
  logic             busy;
  logic [1:0]       state_dbg;

  int vectors;
  int miscompares;

  or_acc_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; len = '0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ctrl busy=%b done=%b in_ready=%b want 000", busy, done, in_ready); end
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL reset_result got %h want 00", result); end
    step; step;
    rst = 1'b1;
    step;
    vectors++; if (state_dbg !== 2'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle state=%0d busy=%b want 0 0", state_dbg, busy); end
  endtask

  task automatic test_basic;
    int busy_cnt = 0;
    start = 1'b1; len = 5'd3;
    step;
    start = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    vectors++; if (in_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL basic_acc in_ready=%b done=%b want 1 0", in_ready, done); end
    in_valid = 1'b1; in_data = 8'h01; step; if (busy === 1'b1) busy_cnt++;
    in_data = 8'h10; step; if (busy === 1'b1) busy_cnt++;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_early_done got %b want 0", done); end
    in_data = 8'h80; step; if (busy === 1'b1) busy_cnt++;
    in_valid = 1'b0; in_data = '0;
    vectors++; if (done !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_done done=%b in_ready=%b want 1 0", done, in_ready); end
    vectors++; if (result !== 8'h91) begin miscompares++; $display("FAIL basic_result got %h want 91", result); end
    step; if (busy === 1'b1) busy_cnt++;
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle done=%b busy=%b want 0 0", done, busy); end
    vectors++; if (busy_cnt != 4) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 4", busy_cnt); end
  endtask

  task automatic test_clear_mid;
    start = 1'b1; len = 5'd4;
    step;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; step;
    in_data = 8'h02; step;
    in_valid = 1'b0; clear = 1'b1;
    step;
    clear = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL clear_mid_ctrl busy=%b done=%b in_ready=%b want 000", busy, done, in_ready); end
    vectors++; if (result !== 8'h91) begin miscompares++; $display("FAIL clear_mid_result got %h want 91", result); end
    step;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL clear_mid_no_done got %b want 0", done); end
  endtask

  task automatic test_stall;
    logic       vpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] dpat [4] = '{8'h0F, 8'h33, 8'h44, 8'hF0};
    start = 1'b1; len = 5'd2;
    step;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = vpat[i]; in_data = dpat[i];
      step;
      if (i < 3) begin
        vectors++; if (done !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_hold_%0d done=%b in_ready=%b want 0 1", i, done, in_ready); end
      end
    end
    in_valid = 1'b0; in_data = '0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got %b want 1", done); end
    vectors++; if (result !== 8'hFF) begin miscompares++; $display("FAIL stall_result got %h want ff", result); end
    step;
  endtask

  task automatic test_zero_len;
    int ready_seen = 0;
    start = 1'b1; len = 5'd0;
    step;
    start = 1'b0;
    if (in_ready === 1'b1) ready_seen++;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done got %b want 1", done); end
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL zero_result got %h want 00", result); end
    step;
    if (in_ready === 1'b1) ready_seen++;
    vectors++; if (done !== 1'b0 || busy !== 1'b0 || ready_seen != 0) begin miscompares++; $display("FAIL zero_after done=%b busy=%b ready_seen=%0d want 0 0 0", done, busy, ready_seen); end
  endtask

  task automatic test_clear_start;
    clear = 1'b1; start = 1'b1; len = 5'd2;
    step;
    clear = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin miscompares++; $display("FAIL clear_start busy=%b state=%0d want 0 0", busy, state_dbg); end
  endtask

  task automatic test_clear_final;
    start = 1'b1; len = 5'd1;
    step;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; clear = 1'b1;
    step;
    in_valid = 1'b0; clear = 1'b0;
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL clear_final_ctrl done=%b busy=%b want 0 0", done, busy); end
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL clear_final_result got %h want 00", result); end
  endtask

  task automatic test_start_ignored;
    int done_cnt = 0;
    start = 1'b1; len = 5'd2;
    step;
    len = 5'd5;
    in_valid = 1'b1; in_data = 8'h01; step; if (done === 1'b1) done_cnt++;
    in_data = 8'h02; step; if (done === 1'b1) done_cnt++;
    in_valid = 1'b0;
    vectors++; if (result !== 8'h03) begin miscompares++; $display("FAIL ignore_result got %h want 03", result); end
    step; if (done === 1'b1) done_cnt++;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_done_start busy=%b want 0", busy); end
    start = 1'b0;
    step; if (done === 1'b1) done_cnt++;
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_async_reset;
    start = 1'b1; len = 5'd3;
    step;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h0F; step;
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin miscompares++; $display("FAIL async_ctrl busy=%b in_ready=%b done=%b state=%0d want 0 0 0 0", busy, in_ready, done, state_dbg); end
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL async_result got %h want 00", result); end
    #2 rst = 1'b1;
    start = 1'b1; len = 5'd1;
    step;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; step;
    in_valid = 1'b0;
    vectors++; if (done !== 1'b1 || result !== 8'hAA) begin miscompares++; $display("FAIL async_rerun done=%b result=%h want 1 aa", done, result); end
    step;
  endtask

  task automatic test_back_to_back;
    start = 1'b1; len = 5'd1;
    step;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step;
    in_valid = 1'b0;
    vectors++; if (done !== 1'b1 || result !== 8'h11) begin miscompares++; $display("FAIL b2b_first done=%b result=%h want 1 11", done, result); end
    start = 1'b1; len = 5'd1;
    step;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_gap busy=%b want 0", busy); end
    step;
    start = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_accept in_ready=%b want 1", in_ready); end
    in_valid = 1'b1; in_data = 8'h22; step;
    in_valid = 1'b0;
    vectors++; if (done !== 1'b1 || result !== 8'h22) begin miscompares++; $display("FAIL b2b_second done=%b result=%h want 1 22", done, result); end
    step;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_clear_mid();
    test_stall();
    test_zero_len();
    test_clear_start();
    test_clear_final();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
